// File: rtl/wb_axil_bridge_ctrl_pkg.sv
// Shared types and constants for the Wishbone-to-AXI4-Lite bridge controller.
// Optional phase timeout is enabled with the WB_AXIL_TIMEOUT_EN macro.
package wb_axil_bridge_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        TERM
    } state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    function automatic int unsigned strb_width(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/wb_axil_phase_timer.sv
// Per-phase wait counter for the bridge controller; only instantiated when
// WB_AXIL_TIMEOUT_EN is defined.
module wb_axil_phase_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (run && !expired) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // The phase has been waiting TIMEOUT_CYCLES cycles once the count reaches the last index.
    assign expired = run && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_axil_bridge_ctrl.sv
// Single-outstanding Wishbone classic slave to AXI4-Lite master sequencer.
// Define WB_AXIL_TIMEOUT_EN to bound each AXI phase to TIMEOUT_CYCLES cycles.
module wb_axil_bridge_ctrl
    import wb_axil_bridge_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  wb_cyc_i,
    input  logic                                  wb_stb_i,
    input  logic                                  wb_we_i,
    input  logic [ADDR_WIDTH-1:0]                 wb_adr_i,
    input  logic [DATA_WIDTH-1:0]                 wb_dat_i,
    input  logic [strb_width(DATA_WIDTH)-1:0]     wb_sel_i,
    output logic [DATA_WIDTH-1:0]                 wb_dat_o,
    output logic                                  wb_ack_o,
    output logic                                  wb_err_o,
    output logic                                  awvalid,
    input  logic                                  awready,
    output logic [ADDR_WIDTH-1:0]                 awaddr,
    output logic                                  wvalid,
    input  logic                                  wready,
    output logic [DATA_WIDTH-1:0]                 wdata,
    output logic [strb_width(DATA_WIDTH)-1:0]     wstrb,
    input  logic                                  bvalid,
    output logic                                  bready,
    input  logic [1:0]                            bresp,
    output logic                                  arvalid,
    input  logic                                  arready,
    output logic [ADDR_WIDTH-1:0]                 araddr,
    input  logic                                  rvalid,
    output logic                                  rready,
    input  logic [DATA_WIDTH-1:0]                 rdata,
    input  logic [1:0]                            rresp
);

    localparam int unsigned STRB_W = strb_width(DATA_WIDTH);

    state_t                  state_q, state_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic                    drop_q, drop_d;
    logic [1:0]              resp_q, resp_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [DATA_WIDTH-1:0]   dat_q, dat_d;
    logic [STRB_W-1:0]       sel_q, sel_d;
    logic [DATA_WIDTH-1:0]   rdat_d;
    logic                    timeout_hit;

`ifdef WB_AXIL_TIMEOUT_EN
    logic phase_run;

    assign phase_run = state_q inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP};

    wb_axil_phase_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_phase_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_d != state_q),
        .run     (phase_run),
        .expired (timeout_hit)
    );
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    // Only resp[1] decides ack versus err; bit 0 is captured for completeness.
    logic unused_resp_lsb;
    assign unused_resp_lsb = resp_q[0];

    assign awaddr = adr_q;
    assign araddr = adr_q;
    assign wdata  = dat_q;
    assign wstrb  = sel_q;

    always_comb begin
        // NOTE: every signal gets a hold value first so no path through the case infers a latch.
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        drop_d    = drop_q;
        resp_d    = resp_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        rdat_d    = wb_dat_o;

        // A master that abandons the cycle still lets the AXI side finish cleanly.
        if ((state_q inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP}) && !wb_cyc_i) begin
            drop_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    adr_d     = wb_adr_i;
                    dat_d     = wb_dat_i;
                    sel_d     = wb_sel_i;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    drop_d    = 1'b0;
                    resp_d    = AXI_RESP_OKAY;
                    state_d   = wb_we_i ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                if (awvalid && awready) aw_done_d = 1'b1;
                if (wvalid && wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) begin
                    state_d = WR_RESP;
                end else if (timeout_hit) begin
                    resp_d  = AXI_RESP_SLVERR;
                    state_d = TERM;
                end
            end
            WR_RESP: begin
                if (bvalid) begin
                    resp_d  = bresp;
                    state_d = TERM;
                end else if (timeout_hit) begin
                    resp_d  = AXI_RESP_SLVERR;
                    state_d = TERM;
                end
            end
            RD_REQ: begin
                if (arready) begin
                    state_d = RD_RESP;
                end else if (timeout_hit) begin
                    resp_d  = AXI_RESP_SLVERR;
                    state_d = TERM;
                end
            end
            RD_RESP: begin
                if (rvalid) begin
                    rdat_d  = rdata;
                    resp_d  = rresp;
                    state_d = TERM;
                end else if (timeout_hit) begin
                    resp_d  = AXI_RESP_SLVERR;
                    state_d = TERM;
                end
            end
            TERM:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next-state view so they line up with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            drop_q    <= 1'b0;
            resp_q    <= AXI_RESP_OKAY;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            wb_dat_o  <= '0;
            wb_ack_o  <= 1'b0;
            wb_err_o  <= 1'b0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            drop_q    <= drop_d;
            resp_q    <= resp_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            wb_dat_o  <= rdat_d;
            wb_ack_o  <= (state_d == TERM) && !drop_d && !resp_d[1];
            wb_err_o  <= (state_d == TERM) && !drop_d &&  resp_d[1];
            awvalid   <= (state_d == WR_REQ) && !aw_done_d;
            wvalid    <= (state_d == WR_REQ) && !w_done_d;
            bready    <= (state_d == WR_RESP);
            arvalid   <= (state_d == RD_REQ);
            rready    <= (state_d == RD_RESP);
        end
    end

endmodule

// File: tb/tb_wb_axil_bridge_ctrl.sv
// Directed bench for wb_axil_bridge_ctrl with a configurable-latency AXI4-Lite slave.
// The timeout sequence runs only when WB_AXIL_TIMEOUT_EN is defined.
module tb_wb_axil_bridge_ctrl;
    import wb_axil_bridge_ctrl_pkg::*;

    localparam int BUDGET = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_ack_o, wb_err_o;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int checks = 0;
    int errors = 0;

    // slave configuration and bookkeeping
    int          cfg_aw_wait = 0, cfg_w_wait = 0, cfg_ar_wait = 0;
    logic [1:0]  cfg_resp  = 2'b00;
    logic [31:0] cfg_rdata = '0;
    int          aw_cnt, w_cnt, ar_cnt;
    int          n_aw, n_w, n_b, n_ar, n_r;
    logic        aw_got, w_got, bvalid_q, rvalid_q;
    logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
    logic [3:0]  cap_wstrb;

    always #5 clk = ~clk;

    wb_axil_bridge_ctrl #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_we_i  (wb_we_i),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_sel_i (wb_sel_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .wb_err_o (wb_err_o),
        .awvalid  (awvalid),
        .awready  (awready),
        .awaddr   (awaddr),
        .wvalid   (wvalid),
        .wready   (wready),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .bvalid   (bvalid),
        .bready   (bready),
        .bresp    (bresp),
        .arvalid  (arvalid),
        .arready  (arready),
        .araddr   (araddr),
        .rvalid   (rvalid),
        .rready   (rready),
        .rdata    (rdata),
        .rresp    (rresp)
    );

    // Ready rises once valid has waited the configured number of cycles.
    assign awready = awvalid && (aw_cnt >= cfg_aw_wait);
    assign wready  = wvalid  && (w_cnt  >= cfg_w_wait);
    assign arready = arvalid && (ar_cnt >= cfg_ar_wait);
    assign bvalid  = bvalid_q;
    assign rvalid  = rvalid_q;
    assign bresp   = cfg_resp;
    assign rresp   = cfg_resp;
    assign rdata   = cfg_rdata;

    always @(posedge clk) begin
        if (rst) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; bvalid_q <= 1'b0; rvalid_q <= 1'b0;
        end else begin
            aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (wvalid  && !wready)  ? w_cnt  + 1 : 0;
            ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
            if (awvalid && awready) begin
                aw_got <= 1'b1; n_aw <= n_aw + 1; cap_awaddr <= awaddr;
            end
            if (wvalid && wready) begin
                w_got <= 1'b1; n_w <= n_w + 1; cap_wdata <= wdata; cap_wstrb <= wstrb;
            end
            if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready)) && !bvalid_q) begin
                bvalid_q <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
            end
            if (bvalid_q && bready) begin
                bvalid_q <= 1'b0; n_b <= n_b + 1;
            end
            if (arvalid && arready) begin
                rvalid_q <= 1'b1; n_ar <= n_ar + 1; cap_araddr <= araddr;
            end
            if (rvalid_q && rready) begin
                rvalid_q <= 1'b0; n_r <= n_r + 1;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives a request and returns #1 after the edge that samples it (cycle count 1).
    task automatic wb_start(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel);
        @(posedge clk); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = sel;
        @(posedge clk); #1;
    endtask

    // Latency = edges from the stb-sampling edge to the edge that samples ack/err.
    task automatic wb_finish(input int n0, output logic ack, output logic err, output int lat);
        ack = 1'b0; err = 1'b0; lat = -1;
        for (int n = n0; n <= n0 + BUDGET; n++) begin
            if (wb_ack_o || wb_err_o) begin
                ack = wb_ack_o; err = wb_err_o; lat = n;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        check("single_pulse", {62'd0, wb_ack_o, wb_err_o}, 64'd0);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          aw_wait;
        int          w_wait;
        int          ar_wait;
        logic [1:0]  resp;
        logic [31:0] rdat;
        logic        exp_ack;
        logic        exp_err;
        logic [31:0] exp_dat;
        int          exp_lat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic ack, err;
        int   lat, b0, r0, aw0, saw, arv_cnt, err_cnt, ack_cnt;

        n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
        cap_awaddr = '0; cap_wdata = '0; cap_araddr = '0; cap_wstrb = '0;
        rst = 1'b1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;

        //            we    adr           dat           sel   aw w  ar resp   rdat          ack   err   dat           lat
        vecs[0] = '{1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 2'b00, 32'h0,        1'b1, 1'b0, 32'h0,        3};
        vecs[1] = '{1'b0, 32'h0000_2004, 32'h0,        4'hF, 0, 0, 0, 2'b10, 32'h1234_5678, 1'b0, 1'b1, 32'h1234_5678, 3};
        vecs[2] = '{1'b1, 32'h0000_3000, 32'hA5A5_0F0F, 4'h3, 3, 1, 0, 2'b10, 32'h0,        1'b0, 1'b1, 32'h1234_5678, 6};
        vecs[3] = '{1'b0, 32'h0000_0040, 32'h0,        4'hF, 0, 0, 2, 2'b00, 32'hCAFE_F00D, 1'b1, 1'b0, 32'hCAFE_F00D, 5};
        vecs[4] = '{1'b1, 32'h0000_0FFC, 32'h0102_0304, 4'h8, 2, 0, 0, 2'b01, 32'h0,        1'b1, 1'b0, 32'hCAFE_F00D, 5};
        vecs[5] = '{1'b0, 32'h0000_7FFC, 32'h0,        4'hF, 0, 0, 0, 2'b11, 32'h0F1E_2D3C, 1'b0, 1'b1, 32'h0F1E_2D3C, 3};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_handshake_outs", {59'd0, awvalid, wvalid, bready, arvalid, rready}, 64'd0);
        check("rst_term", {62'd0, wb_ack_o, wb_err_o}, 64'd0);
        check("rst_dat_o", {32'd0, wb_dat_o}, 64'd0);
        check("rst_latched", {awaddr, wdata}, 64'd0);
        check("rst_wstrb", {60'd0, wstrb}, 64'd0);

        for (int i = 0; i < 6; i++) begin
            cfg_aw_wait = vecs[i].aw_wait; cfg_w_wait = vecs[i].w_wait;
            cfg_ar_wait = vecs[i].ar_wait; cfg_resp = vecs[i].resp; cfg_rdata = vecs[i].rdat;
            b0 = n_b; r0 = n_r; aw0 = n_aw;
            wb_start(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel);
            wb_finish(1, ack, err, lat);
            check($sformatf("v%0d_ack_err", i), {62'd0, ack, err}, {62'd0, vecs[i].exp_ack, vecs[i].exp_err});
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_dat_o", i), wb_dat_o, vecs[i].exp_dat);
            if (vecs[i].we) begin
                check($sformatf("v%0d_awaddr", i), cap_awaddr, vecs[i].adr);
                check($sformatf("v%0d_wdata", i), cap_wdata, vecs[i].dat);
                check($sformatf("v%0d_wstrb", i), cap_wstrb, vecs[i].sel);
                check($sformatf("v%0d_wr_hs", i), {n_aw - aw0, n_b - b0}, {32'd1, 32'd1});
            end else begin
                check($sformatf("v%0d_araddr", i), cap_araddr, vecs[i].adr);
                check($sformatf("v%0d_r_hs", i), n_r - r0, 1);
            end
        end

        // wready arrives 4 cycles after the AW handshake
        cfg_aw_wait = 0; cfg_w_wait = 4; cfg_resp = 2'b00;
        b0 = n_b;
        wb_start(1'b1, 32'h0000_5000, 32'h5555_AAAA, 4'hF);
        check("wdly_both_valid", {62'd0, awvalid, wvalid}, 64'd3);
        @(posedge clk); #1;
        check("wdly_aw_dropped", {62'd0, awvalid, wvalid}, 64'd1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("wdly_w_held", {62'd0, awvalid, wvalid}, 64'd1);
        check("wdly_no_b_yet", n_b - b0, 0);
        wb_finish(5, ack, err, lat);
        check("wdly_ack", {62'd0, ack, err}, 64'd2);
        check("wdly_latency", lat, 7);
        check("wdly_one_b", n_b - b0, 1);

        // cyc dropped while the read response is pending
        cfg_w_wait = 0; cfg_rdata = 32'h0BAD_F00D;
        r0 = n_r; saw = 0;
        wb_start(1'b0, 32'h0000_6000, 32'h0, 4'hF);
        @(posedge clk); #1;
        check("drop_in_rd_resp", {63'd0, rready}, 64'd1);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (wb_ack_o || wb_err_o) saw++;
        end
        check("drop_no_term", saw, 0);
        check("drop_r_hs", n_r - r0, 1);

        // reset while waiting for the write response
        wb_start(1'b1, 32'h0000_7000, 32'h1111_2222, 4'hF);
        @(posedge clk); #1;
        check("mid_rst_in_wr_resp", {63'd0, bready}, 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        check("mid_rst_outs", {61'd0, awvalid, wvalid, bready}, 64'd0);
        check("mid_rst_state", dut.state_q, IDLE);
        b0 = n_b;
        wb_start(1'b1, 32'h0000_8000, 32'h3333_4444, 4'hC);
        wb_finish(1, ack, err, lat);
        check("post_rst_ack", {62'd0, ack, err}, 64'd2);
        check("post_rst_latency", lat, 3);
        check("post_rst_wdata", cap_wdata, 32'h3333_4444);
        check("post_rst_b", n_b - b0, 1);

`ifdef WB_AXIL_TIMEOUT_EN
        // AR never accepted: arvalid held for 8 cycles then a single err
        cfg_ar_wait = 1000;
        arv_cnt = 0; err_cnt = 0; ack_cnt = 0;
        wb_start(1'b0, 32'h0000_9000, 32'h0, 4'hF);
        for (int n = 0; n < 24; n++) begin
            if (arvalid)  arv_cnt++;
            if (wb_ack_o) ack_cnt++;
            if (wb_err_o) begin
                err_cnt++;
                wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
            end
            @(posedge clk); #1;
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        check("to_arvalid_cycles", arv_cnt, 8);
        check("to_err_pulses", err_cnt, 1);
        check("to_no_ack", ack_cnt, 0);
        check("to_arvalid_low", {63'd0, arvalid}, 64'd0);
        cfg_ar_wait = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_axil_bridge_ctrl.md
Name:
wb_axil_bridge_ctrl

Overview:
Sequencing controller that turns single Wishbone classic slave cycles from the wb_master agent side into AXI4-Lite master transactions toward the axi_slave side. It handles exactly one transaction at a time: it latches the Wishbone request, drives the AW/W or AR channel, collects B or R, and returns ack or err plus read data. It is the control core of the block_3 Wishbone-to-AXI path.

Parameters:
ADDR_WIDTH, 32, address width on both buses
DATA_WIDTH, 32, data width on both buses (multiple of 8; strobe width is DATA_WIDTH/8)
TIMEOUT_CYCLES, 255, maximum wait per AXI phase when WB_AXIL_TIMEOUT_EN is defined

Ports:
clk  in  1  single clock for all logic
rst  in  1  synchronous reset, active-high
wb_cyc_i  in  1  Wishbone cycle
wb_stb_i  in  1  Wishbone strobe
wb_we_i  in  1  1 = write
wb_adr_i  in  ADDR_WIDTH  byte address
wb_dat_i  in  DATA_WIDTH  write data
wb_sel_i  in  DATA_WIDTH/8  byte selects
wb_dat_o  out  DATA_WIDTH  read data
wb_ack_o  out  1  normal termination, one-cycle pulse
wb_err_o  out  1  error termination, one-cycle pulse
awvalid  out  1  write address valid
awready  in  1  write address ready
awaddr  out  ADDR_WIDTH  write address
wvalid  out  1  write data valid
wready  in  1  write data ready
wdata  out  DATA_WIDTH  write data
wstrb  out  DATA_WIDTH/8  write strobes (= latched wb_sel_i)
bvalid  in  1  write response valid
bready  out  1  write response ready
bresp  in  2  write response
arvalid  out  1  read address valid
arready  in  1  read address ready
araddr  out  ADDR_WIDTH  read address
rvalid  in  1  read data valid
rready  out  1  read data ready
rdata  in  DATA_WIDTH  read data
rresp  in  2  read response

Behaviour:
- Reset (synchronous, highest priority, also applies mid-transaction): state IDLE. All valid/ready outputs, wb_ack_o, wb_err_o and wb_dat_o are 0. The latched address, data and strobe are 0. Outstanding AXI handshakes are abandoned, so the bench resets the AXI slave together with this block.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, TERM. All outputs are registered.
- IDLE: when wb_cyc_i & wb_stb_i are sampled high, latch adr, dat, sel and we. Go to WR_REQ if we=1, otherwise RD_REQ.
- WR_REQ: awvalid and wvalid are both asserted. Each one drops independently on its own handshake (valid & ready); order and simultaneity are free. Completion is tracked with aw_done and w_done flags. Once both are done, go to WR_RESP. A valid signal never drops before its handshake.
- WR_RESP: bready=1. On bvalid, capture bresp and go to TERM.
- RD_REQ: arvalid=1. On arready, go to RD_RESP.
- RD_RESP: rready=1. On rvalid, register wb_dat_o<=rdata, capture rresp and go to TERM.
- TERM: for one cycle, wb_ack_o=1 if resp[1]==0, otherwise wb_err_o=1. Return to IDLE; a new request is sampled on the following cycle.
- Termination suppression: if wb_cyc_i drops at any point after the request is latched, the AXI transaction still completes, but no ack or err is issued.
- wb_dat_o holds the last read data until the next read completes.
- Minimum latency, with zero-wait AXI ready/valid: stb sampled at cycle 0 gives ack at cycle 3 for both reads and writes.

Optional Feature:
WB_AXIL_TIMEOUT_EN: a per-phase wait counter runs in WR_REQ, WR_RESP, RD_REQ and RD_RESP, and is cleared on every state change. When the count reaches TIMEOUT_CYCLES, the block drops all AXI valid/ready signals, pulses wb_err_o in TERM and returns to IDLE. Without the macro there is no counter and the block waits indefinitely.

Decomposition:
- Package wb_axil_bridge_ctrl_pkg holds the state enum, AXI_RESP_OKAY=2'b00 and AXI_RESP_SLVERR=2'b10, and the strobe width function.
- Natural sub-module: wb_axil_phase_timer, the timeout counter, instantiated only under WB_AXIL_TIMEOUT_EN.

Test Plan:
- Write of 0xDEADBEEF to 0x1000, sel=4'hF, zero-wait slave -> awaddr=0x1000, wdata=0xDEADBEEF, wstrb=4'hF; ack exactly 3 cycles after stb; one ack pulse.
- wready asserted 4 cycles after awready -> awvalid drops after its handshake, wvalid stays high until its own handshake; a single B handshake; then ack.
- Read of 0x2004, rdata=0x12345678, rresp=2'b10 -> wb_err_o pulse, wb_ack_o=0, wb_dat_o=0x12345678.
- wb_cyc_i dropped during RD_RESP -> the R handshake completes, and neither ack nor err is asserted.
- rst asserted during WR_RESP -> next cycle awvalid=wvalid=bready=0 and state is IDLE; the following write completes normally.
- With WB_AXIL_TIMEOUT_EN and TIMEOUT_CYCLES=8, arready held low -> arvalid drops after 8 cycles and wb_err_o pulses once.
